// File: rtl/pipe_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_adder: STAGES-deep sliced ripple adder with valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.  Rev 1.0
// ----------------------------------------------------------------------------
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int W = WIDTH / STAGES;

  logic             w_advance;
  logic             w_accept;
  logic [WIDTH-1:0] w_bp;
  logic             w_c0;

  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance;
  assign w_accept  = in_valid & w_advance;
  assign w_bp      = sub ? ~b : b;
  assign w_c0      = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * W;
    localparam int HI = LO + W;

    logic [W-1:0]  w_a_sl;
    logic [W-1:0]  w_b_sl;
    logic          w_c_in;
    logic [W:0]    w_add;
    logic          valid_d, valid_q;
    logic          carry_d, carry_q;
    logic [HI-1:0] sum_d, sum_q;

    if (k == 0) begin : g_first
      assign valid_d = w_accept;
      assign w_a_sl  = a[W-1:0];
      assign w_b_sl  = w_bp[W-1:0];
      assign w_c_in  = w_c0;
      assign sum_d   = w_add[W-1:0];
    end else begin : g_next
      assign valid_d = g_stage[k-1].valid_q;
      assign w_a_sl  = g_stage[k-1].g_skew.a_q[W-1:0];
      assign w_b_sl  = g_stage[k-1].g_skew.b_q[W-1:0];
      assign w_c_in  = g_stage[k-1].carry_q;
      assign sum_d   = {w_add[W-1:0], g_stage[k-1].sum_q};
    end

    assign w_add   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{W{1'b0}}, w_c_in};
    assign carry_d = w_add[W];

    // Bubbles shift with the data so result spacing is preserved across stalls.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (w_advance) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    // Operand slices not yet consumed travel alongside the partial sum.
    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-HI-1:0] a_d, a_q;
      logic [WIDTH-HI-1:0] b_d, b_q;

      if (k == 0) begin : g_load
        assign a_d = a[WIDTH-1:HI];
        assign b_d = w_bp[WIDTH-1:HI];
      end else begin : g_shift
        assign a_d = g_stage[k-1].g_skew.a_q[WIDTH-LO-1:W];
        assign b_d = g_stage[k-1].g_skew.b_q[WIDTH-LO-1:W];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (w_advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;

`ifdef PIPE_ADDER_OVF_EN
  // Sign bits of both operands are only visible in the final slice.
  logic ovf_d, ovf_q;

  assign ovf_d = (g_stage[STAGES-1].w_a_sl[W-1] == g_stage[STAGES-1].w_b_sl[W-1]) &&
                 (g_stage[STAGES-1].w_add[W-1] != g_stage[STAGES-1].w_a_sl[W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (w_advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_adder: scoreboard bench for pipe_adder (8/2 directed, 4/2 sweep).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       rst8_n, iv8, ir8, cin8, sub8, ov8, or8, co8;
  logic [7:0] a8, b8, s8;
  logic       rst4_n, iv4, ir4, cin4, sub4, ov4, or4, co4;
  logic [3:0] a4, b4, s4;
`ifdef PIPE_ADDER_OVF_EN
  logic       of8, of4;
`endif

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(of8)
`endif
  );

  pipe_adder #(.WIDTH(4), .STAGES(2)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(of4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] e8(input logic [7:0] s, input logic c, input logic o);
    return {OVF_ON ? o : 1'b0, c, s};
  endfunction

  function automatic logic [9:0] act8();
`ifdef PIPE_ADDER_OVF_EN
    return {of8, co8, s8};
`else
    return {1'b0, co8, s8};
`endif
  endfunction

  function automatic logic [5:0] act4();
`ifdef PIPE_ADDER_OVF_EN
    return {of4, co4, s4};
`else
    return {1'b0, co4, s4};
`endif
  endfunction

  logic [9:0] q8[$];
  logic [5:0] q4[$];

  // Monitors: a result transfers on the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rst8_n && ov8 && or8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out8_unexpected: got %0h expected none", act8());
      end else begin
        chk("out8", {22'd0, act8()}, {22'd0, q8.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst4_n && ov4 && or4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out4_unexpected: got %0h expected none", act4());
      end else begin
        chk("out4", {26'd0, act4()}, {26'd0, q4.pop_front()});
      end
    end
  end

  task automatic send8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic is, input logic [9:0] exp);
    logic acc;
    int   n;
    iv8 = 1'b1; a8 = ia; b8 = ib; cin8 = ic; sub8 = is;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ir8 && rst8_n;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) begin
      q8.push_back(exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL send8_timeout: got in_ready=0 expected accept within 50 cycles");
    end
    iv8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] ia, input logic [3:0] ib, input logic ic, input logic is);
    logic [3:0] bp;
    logic [4:0] full;
    logic       o, acc;
    int         n;
    bp   = is ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, bp} + {4'd0, (is ? 1'b1 : ic)};
    o    = (ia[3] == bp[3]) && (full[3] != ia[3]);
    iv4 = 1'b1; a4 = ia; b4 = ib; cin4 = ic; sub4 = is;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      or4 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = ir4 && rst4_n;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) begin
      q4.push_back({OVF_ON ? o : 1'b0, full});
    end else begin
      checks++;
      errors++;
      $display("FAIL send4_timeout: got in_ready=0 expected accept within 50 cycles");
    end
    iv4 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst8_n = 1'b0; iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
    rst4_n = 1'b0; iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; sub4 = 1'b0; or4 = 1'b1;

    // Reset state, with a valid input held during reset that must be ignored.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_sum", {24'd0, s8}, 32'd0);
    chk("rst_cout", {31'd0, co8}, 32'd0);
    chk("rst_in_ready", {31'd0, ir8}, 32'd1);
    @(posedge clk); #1;
    iv8 = 1'b0; rst8_n = 1'b1; rst4_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_accept", {31'd0, ov8}, 32'd0);
    end
    @(posedge clk); #1;

    // Single transfer and latency.
    send8(8'h7F, 8'h01, 1'b0, 1'b0, e8(8'h80, 1'b0, 1'b1));
    @(negedge clk);
    chk("lat_cycle1", {31'd0, ov8}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2", {31'd0, ov8}, 32'd1);
    chk("lat_sum", {22'd0, act8()}, {22'd0, e8(8'h80, 1'b0, 1'b1)});
    @(posedge clk); #1;

    // Subtract, cin ignored, plus a few more directed vectors.
    send8(8'h05, 8'h07, 1'b1, 1'b1, e8(8'hFE, 1'b0, 1'b0));
    send8(8'h80, 8'h80, 1'b0, 1'b0, e8(8'h00, 1'b1, 1'b1));
    send8(8'hFF, 8'hFF, 1'b1, 1'b0, e8(8'hFF, 1'b1, 1'b0));
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back: three results on consecutive cycles.
    send8(8'h0F, 8'h01, 1'b0, 1'b0, e8(8'h10, 1'b0, 1'b0));
    send8(8'hFF, 8'h01, 1'b0, 1'b0, e8(8'h00, 1'b1, 1'b0));
    send8(8'h10, 8'h10, 1'b0, 1'b0, e8(8'h20, 1'b0, 1'b0));
    @(negedge clk);
    chk("b2b_valid2", {31'd0, ov8}, 32'd1);
    @(negedge clk);
    chk("b2b_valid3", {31'd0, ov8}, 32'd1);
    @(negedge clk);
    chk("b2b_idle", {31'd0, ov8}, 32'd0);
    @(posedge clk); #1;

    // Stall: held result frozen, input blocked, then released in order.
    or8 = 1'b0;
    send8(8'h80, 8'h01, 1'b0, 1'b1, e8(8'h7F, 1'b1, 1'b1));
    send8(8'h12, 8'h34, 1'b1, 1'b0, e8(8'h47, 1'b0, 1'b0));
    iv8 = 1'b1; a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, ir8}, 32'd0);
      chk("stall_valid", {31'd0, ov8}, 32'd1);
      chk("stall_out", {22'd0, act8()}, {22'd0, e8(8'h7F, 1'b1, 1'b1)});
    end
    @(posedge clk); #1;
    or8 = 1'b1;
    send8(8'h55, 8'h22, 1'b0, 1'b0, e8(8'h77, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    chk("stall_drained", q8.size(), 32'd0);

    // Reset one cycle after a transfer discards the in-flight result.
    send8(8'h10, 8'h10, 1'b0, 1'b1, e8(8'h00, 1'b1, 1'b0));
    rst8_n = 1'b0;
    q8.delete();
    @(posedge clk); #1;
    rst8_n = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", {31'd0, ov8}, 32'd0);
    chk("rstmid_in_ready", {31'd0, ir8}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_result", {31'd0, ov8}, 32'd0);
    end
    @(posedge clk); #1;
    send8(8'h12, 8'h34, 1'b0, 1'b0, e8(8'h46, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    chk("final8_drained", q8.size(), 32'd0);

    // Exhaustive 4-bit sweep with randomly throttled out_ready.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          for (int is = 0; is < 2; is++) begin
            send4(ia[3:0], ib[3:0], ic[0], is[0]);
          end
        end
      end
    end
    or4 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("sweep_drained", q4.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
- REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
- REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES; slice width W = WIDTH/STAGES.
- REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
- REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
- REQ-005 SHALL have port in_valid  input  1  operands and controls valid this cycle.
- REQ-006 SHALL have port in_ready  output  1  pipeline accepts input this cycle.
- REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
- REQ-008 SHALL have port b  input  WIDTH  operand B.
- REQ-009 SHALL have port cin  input  1  carry-in, used when sub=0.
- REQ-010 SHALL have port sub  input  1  1 = compute a - b (b inverted, carry-in forced 1, cin ignored).
- REQ-011 SHALL have port out_valid  output  1  sum/cout hold a completed result.
- REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
- REQ-013 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
- REQ-014 SHALL have port cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).

Function
- REQ-015 SHALL define advance = out_ready | ~out_valid; in_ready SHALL equal advance combinationally.
- REQ-016 A transfer SHALL occur on a rising edge when in_valid & in_ready; all pipeline registers, including bubbles, SHALL shift one stage only when advance=1, else hold.
- REQ-017 Stage k (0..STAGES-1) SHALL add slice k of a and b' (b' = sub ? ~b : b) plus the carry registered from stage k-1 (stage 0: sub ? 1 : cin), and register the W-bit partial sum and carry-out.
- REQ-018 Unprocessed upper operand slices and completed lower sum slices SHALL be carried in skew registers so that each result is assembled coherently.
- REQ-019 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1 when advance is held 1; throughput SHALL be one result per cycle.
- REQ-020 Result SHALL satisfy {cout,sum} = a + b' + carry-in, exact in WIDTH+1 bits.
- REQ-021 While out_valid=1 and out_ready=0, sum, cout and out_valid SHALL remain stable and no input SHALL be accepted.
- REQ-022 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
- REQ-023 Results pending when a held result is released SHALL retain their relative spacing; bubbles SHALL NOT be compacted.
- REQ-024 STAGES=1 SHALL degenerate to a single registered adder with latency 1.

Reset
- REQ-025 When rst_n=0 at a rising edge, all stage valid bits, out_valid, sum, cout and all data/skew registers SHALL clear to 0.
- REQ-026 Reset mid-operation SHALL discard every in-flight result; out_valid SHALL be 0 on the first edge after the reset edge, in_ready SHALL then equal 1.
- REQ-027 Inputs presented during reset SHALL NOT be accepted.

Configuration
- REQ-028 Macro PIPE_ADDER_OVF_EN, when defined, SHALL add port ovf  output  1  signed two's-complement overflow of the result, aligned, stalled and reset (to 0) identically with sum.
- REQ-029 ovf SHALL be 1 iff the operand sign bits a[WIDTH-1] and b'[WIDTH-1] are equal and sum[WIDTH-1] differs from them.
- REQ-030 Without PIPE_ADDER_OVF_EN, ovf SHALL not exist and no overflow logic SHALL be present; all other behaviour SHALL be identical.

Verification (WIDTH=8, STAGES=2 unless stated)
- REQ-031 Single transfer: a=0x7F, b=0x01, cin=0, sub=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x80, cout=0, ovf=1 when enabled.
- REQ-032 Subtract: a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, ovf=0; cin ignored.
- REQ-033 Back-to-back: issue 0x0F+0x01, 0xFF+0x01, 0x10+0x10 on consecutive cycles -> consecutive outputs 0x10/0, 0x00/1, 0x20/0 in order.
- REQ-034 Stall: out_ready=0 with a result present -> in_ready=0, sum/cout/out_valid frozen for 3 cycles; on release each result is delivered once, in order.
- REQ-035 Reset mid-flight: assert rst_n=0 one cycle after a transfer -> out_valid never rises for that operand; in_ready=1 after reset.
- REQ-036 Exhaustive sweep: WIDTH=4, STAGES=2, all a, b, cin, sub -> every {cout,sum} matches the reference sum.
